// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and write-request type
//
// Purpose: common sizes for the integer register file and the write-port
//          request record shared by the arbiter and its scoreboard.
// Contents: REG_W (data width), REG_N (entry count), REG_AW (address width),
//           wr_req_t {valid, rd, data}.
package rf_pkg;

  localparam int REG_W  = 64;
  localparam int REG_N  = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_W-1:0]  data;
  } wr_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy vector, outstanding counter and decode hazard lookup
//
// Purpose: remembers which destination registers still wait for a
//          multi-cycle result and how many multi-cycle ops are in flight.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   setEn, setRd        mark setRd busy (issue accepted)
//   clrEn, clrRd        clear clrRd (result accepted)
//   cntInc, cntDec      outstanding counter up/down
//   rs1, rs2, rd, isMc  decode instruction fields
//   hazard              decode must stall (register busy or unit full)
//   busyCnt             outstanding multi-cycle operations
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setEn,
  input  logic [REG_AW-1:0] setRd,
  input  logic              clrEn,
  input  logic [REG_AW-1:0] clrRd,
  input  logic              cntInc,
  input  logic              cntDec,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              isMc,
  output logic              hazard,
  output logic [3:0]        busyCnt
);

  // Bit 0 is kept at zero so x0 always looks free without special-casing
  // the three lookup ports.
  logic [REG_N-1:0] busyQ;
  logic [REG_N-1:0] busyNext;
  logic [3:0]       cntNext;
  logic             full;

  always_comb begin
    busyNext = busyQ;
    if (clrEn) busyNext[clrRd] = 1'b0;
    // A new issue to the register being retired keeps it busy.
    if (setEn) busyNext[setRd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_comb begin
    cntNext = busyCnt;
    if (cntInc && !cntDec) begin
      cntNext = busyCnt + 4'd1;
    end else if (!cntInc && cntDec && busyCnt != 4'd0) begin
      cntNext = busyCnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busyQ   <= '0;
      busyCnt <= 4'd0;
    end else begin
      busyQ   <= busyNext;
      busyCnt <= cntNext;
    end
  end

  assign full   = (busyCnt == 4'(MAX_OUT));
  assign hazard = busyQ[rs1] | busyQ[rs2] | busyQ[rd] | (isMc & full);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with multi-cycle scoreboard
//
// Purpose: shares the single register-file write port between pipeline
//          writeback (priority) and an out-of-band multi-cycle unit, holds
//          the pipeline for one cycle when the multi-cycle result starves,
//          and stalls decode on outstanding destination hazards.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   wb_valid, wb_rd, wb_data       pipeline writeback
//   mc_issue, mc_issue_rd          multi-cycle op leaving issue
//   mc_valid, mc_rd, mc_data       multi-cycle result; mc_ready accepts it
//   id_rs1, id_rs2, id_rd, id_is_mc  decode instruction fields
//   issue_stall                    hold decode (combinational)
//   pipe_hold                      freeze writeback and earlier stages
//   rf_we, rf_waddr, rf_wdata      registered write port
//   busy_cnt                       outstanding multi-cycle operations
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [REG_W-1:0]  wb_data,
  input  logic              mc_issue,
  input  logic [REG_AW-1:0] mc_issue_rd,
  input  logic              mc_valid,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [REG_W-1:0]  mc_data,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_mc,
  output logic              issue_stall,
  output logic              pipe_hold,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_W-1:0]  rf_wdata,
  output logic [3:0]        busy_cnt
);

  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT);

  logic          wbEff;
  logic          mcRefused;
  logic          starveHit;
  logic          issueAcc;
  logic          sbHazard;
  logic [SW-1:0] starveCnt;
  wr_req_t       grant;

  // Writes to x0 are not requests at all.
  assign wbEff     = wb_valid && (wb_rd != '0);
  // In a hold cycle the pipeline result is ignored and re-presented later.
  assign mc_ready  = mc_valid && (!wbEff || pipe_hold);
  assign mcRefused = mc_valid && !mc_ready;
  assign starveHit = mcRefused && (starveCnt == SW'(STARVE_LIMIT - 1));

  assign issue_stall = sbHazard | pipe_hold;
  assign issueAcc    = mc_issue && !issue_stall;

  always_comb begin
    grant = '0;
    if (!pipe_hold && wbEff) begin
      grant = '{valid: 1'b1, rd: wb_rd, data: wb_data};
    end else if (mc_ready && mc_rd != '0) begin
      grant = '{valid: 1'b1, rd: mc_rd, data: mc_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      pipe_hold <= 1'b0;
      starveCnt <= '0;
    end else begin
      rf_we <= grant.valid;
      if (grant.valid) begin
        rf_waddr <= grant.rd;
        rf_wdata <= grant.data;
      end
      // The hold cycle always accepts, so the counter restarts from zero and
      // a second consecutive hold is impossible.
      pipe_hold <= starveHit;
      if (!mcRefused || starveHit) begin
        starveCnt <= '0;
      end else begin
        starveCnt <= starveCnt + SW'(1);
      end
    end
  end

  rf_scoreboard #(
    .MAX_OUT(MAX_OUT)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .setEn  (issueAcc),
    .setRd  (mc_issue_rd),
    .clrEn  (mc_ready),
    .clrRd  (mc_rd),
    .cntInc (issueAcc),
    .cntDec (mc_ready),
    .rs1    (id_rs1),
    .rs2    (id_rs2),
    .rd     (id_rd),
    .isMc   (id_is_mc),
    .hazard (sbHazard),
    .busyCnt(busy_cnt)
  );

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 64-bit, 32-entry integer register file. Shares its single write port between the in-order pipeline writeback and a multi-cycle unit (divider/memory) that returns results out of band. It tracks destination registers with outstanding multi-cycle results and gives the issue stage a hazard stall. It sits between writeback, the multi-cycle unit and the register file write port; reads are not touched.

## Interface
- `MAX_OUT`, 4: maximum outstanding multi-cycle operations, range 1..8.
- `STARVE_LIMIT`, 8: consecutive cycles the multi-cycle result may wait before the pipeline is held.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `wb_valid`  in  1  pipeline writeback present this cycle; cannot be back-pressured except via `pipe_hold`.
- `wb_rd`  in  5  pipeline destination register.
- `wb_data`  in  64  pipeline result.
- `mc_issue`  in  1  multi-cycle op leaves issue this cycle; only sampled when `issue_stall`=0.
- `mc_issue_rd`  in  5  destination of the issuing multi-cycle op.
- `mc_valid`  in  1  multi-cycle result offered.
- `mc_rd`  in  5  multi-cycle result destination.
- `mc_data`  in  64  multi-cycle result.
- `mc_ready`  out  1  multi-cycle result accepted this cycle (combinational).
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register fields of the instruction in decode.
- `id_is_mc`  in  1  decode instruction is a multi-cycle op.
- `issue_stall`  out  1  hold decode (combinational).
- `pipe_hold`  out  1  registered; freeze writeback/earlier stages for one cycle.
- `rf_we`  out  1  registered register-file write enable.
- `rf_waddr`  out  5  registered write address.
- `rf_wdata`  out  64  registered write data.
- `busy_cnt`  out  4  outstanding multi-cycle operations.

## Operation
- Writes to x0 never use the port. A `wb_valid` with `wb_rd`=0 is treated as no request. A `mc_valid` with `mc_rd`=0 is accepted (`mc_ready`=1) but produces no write.
- Arbitration is fixed priority: pipeline first. `mc_ready` = `mc_valid` & (no effective wb request | `pipe_hold`). During a `pipe_hold` cycle the pipeline's `wb_valid` is ignored; upstream guarantees it re-presents the result.
- Starvation counter: increments each cycle `mc_valid`=1 & `mc_ready`=0, and clears on accept or when `mc_valid`=0. When it reaches `STARVE_LIMIT`-1 with the result still refused, `pipe_hold` is asserted for the next single cycle and the counter clears. `pipe_hold` never asserts two cycles in a row.
- Scoreboard `busy[31:1]`:
  - Set on `mc_issue` & `issue_stall`=0 & `mc_issue_rd`≠0.
  - Cleared when `mc_ready`=1 for `mc_rd`.
  - Set and clear of the same index in the same cycle: set wins.
- `busy_cnt`: +1 on an accepted issue with any rd (including x0), −1 on accept. Simultaneous +1/−1 leaves it unchanged. It never exceeds `MAX_OUT` and never goes below 0; violating either is a bench assertion failure.
- `issue_stall` = `busy[id_rs1]` | `busy[id_rs2]` | `busy[id_rd]` | (`id_is_mc` & `busy_cnt`=`MAX_OUT`) | `pipe_hold`. Index 0 always reads not-busy.
- Write port: the granted source's rd/data is registered into `rf_we`/`rf_waddr`/`rf_wdata`. With no grant, `rf_we`=0 and the address/data hold their last values.

## Timing
- Reset, when `rst_n`=0 at an edge:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `pipe_hold`=0, `busy_cnt`=0.
  - Scoreboard and starvation counter are cleared.
  - Reset mid-operation discards all pending state; results arriving afterwards for pre-reset issues are accepted and written normally.
- Write latency: 1 cycle from grant to `rf_we`. The register file commits on the following edge.
- `mc_ready` and `issue_stall` are same-cycle combinational outputs. A busy bit cleared at edge N makes `issue_stall` drop in cycle N+1.
- `pipe_hold` is asserted in the cycle after the threshold cycle. The held result is accepted in that hold cycle.

## Structure
- Shared package `rf_pkg`: `REG_W`=64, `REG_N`=32, `REG_AW`=5, and a `wr_req_t` struct {valid, rd, data}.
- One natural sub-module: `rf_scoreboard`, which holds the busy vector, the counter, and the three-port busy lookup. Arbitration, starvation logic and output registers stay in the top.

## Test plan
- Pipeline write alone: `wb_valid`=1, rd=5, data=0x1234 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234. `wb_rd`=0 → `rf_we`=0.
- Collision: `wb_valid` rd=3 and `mc_valid` rd=7 in the same cycle → rd=3 written and `mc_ready`=0. Next cycle with `wb_valid`=0 → `mc_ready`=1 and rd=7 written.
- Scoreboard hazard: issue mc rd=9; decode `id_rs1`=9 → `issue_stall`=1 until the cycle after mc rd=9 is accepted, then 0. Repeat with `id_rd`=9 for the WAW case.
- Capacity: issue 4 mc ops (rd 1..4) with `MAX_OUT`=4 → `busy_cnt`=4 and `issue_stall`=1 for `id_is_mc`=1 with unrelated regs. One accept → `busy_cnt`=3 and the stall drops.
- Starvation: `mc_valid` held with `wb_valid`=1 (rd≠0) every cycle → `pipe_hold`=1 exactly 8 cycles after `mc_valid` rises. The mc result is written, and `pipe_hold` is back to 0 the following cycle.
- Reset mid-flight: 2 ops outstanding, `rst_n`=0 for one edge → `busy_cnt`=0, all busy bits clear, `rf_we`=0, `issue_stall`=0 for any `id_*` regs.
